// File: rtl/aes_pkg.sv
// Shared definitions for the AES input loader: block geometry, FSM
// encoding and the word-insert helper used when assembling blocks.
package aes_pkg;

  localparam int unsigned WORDS   = 4;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = WORDS * WORD_W;
  localparam int unsigned IDX_W   = $clog2(WORDS);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // FSM encoding kept as plain constants so older code can share it.
  localparam logic [1:0] ST_LOAD_KEY   = 2'd0;
  localparam logic [1:0] ST_LOAD_STATE = 2'd1;
  localparam logic [1:0] ST_ISSUE      = 2'd2;

  // Word n lands at bits [BLOCK_W-1-WORD_W*n -: WORD_W] (MSW first).
  function automatic logic [BLOCK_W-1:0] put_word(
    input logic [BLOCK_W-1:0] blk,
    input logic [IDX_W-1:0]   idx,
    input logic [WORD_W-1:0]  word
  );
    logic [BLOCK_W-1:0] res;
    res = blk;
    res[(BLOCK_W - 1) - (WORD_W * int'(idx)) -: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Generic valid-tag delay line: a DEPTH-stage shift register that
// reproduces valid_i DEPTH edges later on valid_o.
module valid_delay #(
  parameter int unsigned DEPTH = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] tag_q;
  logic [DEPTH-1:0] tag_d;
  logic [DEPTH:0]   shift_s;

  // Next tag vector: shift the new valid bit in at the bottom.
  always_comb begin
    shift_s = {tag_q, valid_i};
    tag_d   = shift_s[DEPTH-1:0];
  end

  // Tag register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign valid_o = tag_q[DEPTH-1];

endmodule

// File: rtl/aes_in_loader.sv
// Assembles a 32-bit word stream into key/state blocks for a fixed-latency
// AES-128 core, tags issued blocks through the core latency and captures
// the matching ciphertext. A held key can be reused to skip key loading.
module aes_in_loader
  import aes_pkg::*;
#(
  parameter int unsigned LATENCY = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_key_reuse,
  output logic [127:0]                  core_state,
  output logic [127:0]                  core_key,
  output logic                          core_issue,
  input  logic [127:0]                  core_out,
  output logic [127:0]                  out_data,
  output logic                          out_valid,
  output logic [$clog2(LATENCY+2)-1:0]  in_flight
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]         fsm_q, fsm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               key_held_q, key_held_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic               issue_q, issue_d;
  logic               ready_q, ready_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer_s;
  logic               tag_last_s;

  assign xfer_s = s_valid & ready_q;

  // Word loading FSM: key words, then state words, then a one-cycle issue.
  always_comb begin
    fsm_d      = fsm_q;
    idx_d      = idx_q;
    key_held_d = key_held_q;
    state_d    = state_q;
    key_d      = key_q;
    case (fsm_q)
      ST_LOAD_KEY: begin
        if (xfer_s) begin
          if ((idx_q == FIRST_IDX) && s_key_reuse && key_held_q) begin
            // Reuse: the first word already belongs to the state.
            state_d = put_word(state_q, FIRST_IDX, s_data);
            idx_d   = IDX_ONE;
            fsm_d   = ST_LOAD_STATE;
          end else begin
            key_d = put_word(key_q, idx_q, s_data);
            if (idx_q == LAST_IDX) begin
              key_held_d = 1'b1;
              idx_d      = FIRST_IDX;
              fsm_d      = ST_LOAD_STATE;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end
        end else begin
          fsm_d = fsm_q;
        end
      end
      ST_LOAD_STATE: begin
        if (xfer_s) begin
          state_d = put_word(state_q, idx_q, s_data);
          if (idx_q == LAST_IDX) begin
            idx_d = FIRST_IDX;
            fsm_d = ST_ISSUE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          fsm_d = fsm_q;
        end
      end
      ST_ISSUE: begin
        fsm_d = ST_LOAD_KEY;
        idx_d = FIRST_IDX;
      end
      default: begin
        fsm_d = ST_LOAD_KEY;
        idx_d = FIRST_IDX;
      end
    endcase
    // Handshake and issue flags are registered views of the next state.
    issue_d = (fsm_d == ST_ISSUE);
    ready_d = (fsm_d != ST_ISSUE);
  end

  // Output capture and saturating in-flight count.
  always_comb begin
    out_valid_d = tag_last_s;
    if (tag_last_s) begin
      out_data_d = core_out;
    end else begin
      out_data_d = out_data_q;
    end
    case ({issue_q, out_valid_q})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (cnt_q == CNT_ZERO) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset wins over any word transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_LOAD_KEY;
      idx_q       <= FIRST_IDX;
      key_held_q  <= 1'b0;
      state_q     <= '0;
      key_q       <= '0;
      issue_q     <= 1'b0;
      ready_q     <= 1'b1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= CNT_ZERO;
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      key_held_q  <= key_held_d;
      state_q     <= state_d;
      key_q       <= key_d;
      issue_q     <= issue_d;
      ready_q     <= ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Issue tags travel alongside the core pipeline.
  valid_delay #(
    .DEPTH(LATENCY)
  ) u_tag (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(issue_q),
    .valid_o(tag_last_s)
  );

  assign s_ready    = ready_q;
  assign core_state = state_q;
  assign core_key   = key_q;
  assign core_issue = issue_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign in_flight  = cnt_q;

endmodule
